mf_clken_gen: RTL and testbench
===============================

# mf_clken_gen

Parametrised clock-enable generator that sits directly behind a core PLL. It derives up to CHANNELS single-cycle enable strobes from one fast PLL output using fractional phase accumulators. The strobes replace extra PLL output counters, and phase-shifted derived clocks are produced as per-channel phase offsets. The block qualifies its outputs with a synchronised, settled PLL lock. Rates and phases are reprogrammed at runtime through a shadow-register handshake, and all channels switch together on commit.

## Interface
Parameters:
- CHANNELS, 4: number of enable outputs (1..16).
- ACC_W, 32: accumulator, increment and phase width.
- LOCK_SYNC, 2: synchroniser depth for pll_locked (≥2).
- SETTLE_CYCLES, 1024: clk_sys cycles between synchronised lock and enable start (≥1).

Ports:
- clk_sys, in, 1: fast PLL output clock; all logic runs on its rising edge.
- reset_n, in, 1: asynchronous active-low reset; release is synchronous to clk_sys upstream.
- pll_locked, in, 1: PLL lock, asynchronous to clk_sys.
- cfg_valid, in, 1: config request.
- cfg_ready, out, 1: config accept; a transfer occurs when cfg_valid && cfg_ready at an edge.
- cfg_commit, in, 1: 0 means shadow write; 1 means commit all shadows.
- cfg_ch, in, max(1,$clog2(CHANNELS)): channel index for a shadow write.
- cfg_inc, in, ACC_W: increment; strobe rate = f_clk_sys·inc/2^ACC_W.
- cfg_phase, in, ACC_W: accumulator preload (phase offset).
- run, out, 1: high while enables are generating.
- clken, out, CHANNELS: per-channel single-cycle enable strobes.

## Operation
- FSM states:
  - WAIT: run=0, clken=0, and accumulators hold the active phase.
  - SETTLE: a counter counts SETTLE_CYCLES; clken=0.
  - RUN: run=1, enables are generating.
- FSM transitions:
  - WAIT→SETTLE when the synchronised lock is 1.
  - SETTLE→RUN when the counter reaches SETTLE_CYCLES−1.
  - Any state→WAIT on synchronised lock=0. Lock loss forces clken=0 and run=0 the next cycle and reloads accumulators from the active phase. The settle counter clears.
- RUN, per channel i, every cycle: {carry,acc_i} ← acc_i + inc_i (ACC_W+1-bit add, wraps mod 2^ACC_W). clken[i] ← carry, registered.
- inc_i=0 means the channel is silent. inc_i=2^ACC_W−1 gives a strobe every cycle after the first addition.
- Shadow write (commit=0): shadow_inc[cfg_ch] ← cfg_inc and shadow_phase[cfg_ch] ← cfg_phase. If cfg_ch ≥ CHANNELS the write is accepted and discarded.
- Commit (commit=1), applied on the same edge for all channels:
  - inc_i ← shadow_inc_i
  - acc_i ← shadow_phase_i
  - clken ← 0
  - cfg_ready drops for exactly the following cycle; a commit never overlaps another config transfer.
  - Commit accepted in WAIT or SETTLE only loads the active registers; generation starts from them at RUN entry.
- Simultaneous commit and lock loss: both take effect. The state goes to WAIT, and the active registers and accumulators take the committed values.
- Reset values:
  - run=0, clken=0, cfg_ready=1.
  - State WAIT, lock synchroniser 0, settle counter 0.
  - All shadow and active inc/phase are 0, and accumulators are 0.

## Timing
- pll_locked to SETTLE entry: LOCK_SYNC+1 edges.
- SETTLE lasts exactly SETTLE_CYCLES cycles.
- Let T0 be the first cycle with run=1, with acc=phase in T0. The addition at the end of Tk is visible as clken in Tk+1.
- First strobe at T_m, where m is the smallest m≥1 with phase + m·inc ≥ 2^ACC_W·(count of strobes so far + 1). This is exact integer arithmetic with no drift.
- Commit accepted at the end of cycle C: clken=0 in C+1, and acc=new phase in C+1. C+1 acts as a new T0.
- Lock drop: run and clken fall LOCK_SYNC+1 edges after pll_locked falls.
- All outputs are registered; there is no combinational path from an input to an output.

## Test plan
- Reset, then pll_locked=1 with SETTLE_CYCLES=16 and inc=0 on all channels: run rises exactly LOCK_SYNC+1+16 edges after lock, and clken stays 0.
- Sequential commits, ACC_W=32, checked for 100 strobes each. Each commit uses a shadow write on ch0 followed by a commit:
  - inc=2^31, phase=0: clken[0] at T2,T4,T6…
  - inc=2^29, phase=0: clken[0] at T8,T16…
  - inc=2^29, phase=2^31: clken[0] at T4,T12…
- Fractional rate inc=0x55555555, phase=0, over 3000 cycles: exactly 1000 strobes, with gaps only 3 or 4 cycles apart (actually every 3rd cycle, ±1).
- Shadow-only behaviour:
  - Shadow writes without commit leave the clken pattern unchanged.
  - A commit realigns all channels: clken=0 the next cycle, and cfg_ready is low for one cycle.
  - A write to cfg_ch=CHANNELS is ignored.
- Lock drop mid-RUN, then relock: clken and run clear after LOCK_SYNC+1 edges, and the full SETTLE repeats. The pattern restarts from phase, with the first strobe at the same T offset as the initial start.
- Assert reset_n mid-RUN and mid-commit: outputs clear asynchronously, and inc=0 after release, so there are no strobes until reprogrammed.

Source files
------------

// File: rtl/mf_clken_gen_if.sv
// Configuration bundle for mf_clken_gen: shadow writes and the commit that
// transfers all shadows to the active rate/phase registers together.
interface mf_clken_gen_if #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 32
) ();
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_commit;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic [ACC_W-1:0] cfg_phase;

  modport master (
    output cfg_valid, cfg_commit, cfg_ch, cfg_inc, cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_commit, cfg_ch, cfg_inc, cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/mf_clken_gen.sv
// Fractional clock-enable generator behind a PLL: per-channel phase
// accumulators produce single-cycle strobes once the PLL lock has settled.
module mf_clken_gen #(
  parameter int CHANNELS      = 4,
  parameter int ACC_W         = 32,
  parameter int LOCK_SYNC     = 2,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                pll_locked_i,
  mf_clken_gen_if.slave       cfg,
  output logic                run_o,
  output logic [CHANNELS-1:0] clken_o
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_RUN} state_e;

  state_e               state_q;
  logic [LOCK_SYNC-1:0] lockSync_q;
  logic [CNT_W-1:0]     settleCnt_q;
  logic                 run_q;
  logic                 cfgReady_q;
  logic [CHANNELS-1:0]  clken_q;

  logic [ACC_W-1:0] shadowInc_q   [CHANNELS];
  logic [ACC_W-1:0] shadowPhase_q [CHANNELS];
  logic [ACC_W-1:0] activeInc_q   [CHANNELS];
  logic [ACC_W-1:0] activePhase_q [CHANNELS];
  logic [ACC_W-1:0] acc_q         [CHANNELS];
  logic [ACC_W:0]   sum_d         [CHANNELS];

  logic lockOk;
  logic xfer;
  logic commitXfer;
  logic writeXfer;
  logic advance;

  assign lockOk     = lockSync_q[LOCK_SYNC-1];
  assign xfer       = cfg.cfg_valid && cfgReady_q;
  assign commitXfer = xfer && cfg.cfg_commit;
  assign writeXfer  = xfer && !cfg.cfg_commit;
  assign advance    = (state_q == ST_RUN) && lockOk;

  assign run_o         = run_q;
  assign clken_o       = clken_q;
  assign cfg.cfg_ready = cfgReady_q;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum_d[i] = {1'b0, acc_q[i]} + {1'b0, activeInc_q[i]};
    end
  end

  // A synchronised lock loss overrides every state and clears the settle count.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_WAIT;
      lockSync_q  <= '0;
      settleCnt_q <= '0;
      run_q       <= 1'b0;
      cfgReady_q  <= 1'b1;
    end else begin
      lockSync_q <= {lockSync_q[LOCK_SYNC-2:0], pll_locked_i};
      cfgReady_q <= !commitXfer;
      if (!lockOk) begin
        state_q     <= ST_WAIT;
        settleCnt_q <= '0;
        run_q       <= 1'b0;
      end else begin
        case (state_q)
          ST_WAIT: begin
            state_q     <= ST_SETTLE;
            settleCnt_q <= '0;
          end
          ST_SETTLE: begin
            if (settleCnt_q == SETTLE_LAST) begin
              state_q     <= ST_RUN;
              settleCnt_q <= '0;
              run_q       <= 1'b1;
            end else begin
              settleCnt_q <= settleCnt_q + 1'b1;
            end
          end
          ST_RUN:  run_q <= 1'b1;
          default: state_q <= ST_WAIT;
        endcase
      end
    end
  end

  // Outside RUN the accumulators sit at the active phase so generation
  // restarts from it; a commit wins over both accumulate and reload.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clken_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadowInc_q[i]   <= '0;
        shadowPhase_q[i] <= '0;
        activeInc_q[i]   <= '0;
        activePhase_q[i] <= '0;
        acc_q[i]         <= '0;
      end
    end else begin
      clken_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (writeXfer && (cfg.cfg_ch == CH_W'(i))) begin
          shadowInc_q[i]   <= cfg.cfg_inc;
          shadowPhase_q[i] <= cfg.cfg_phase;
        end
        if (commitXfer) begin
          activeInc_q[i]   <= shadowInc_q[i];
          activePhase_q[i] <= shadowPhase_q[i];
          acc_q[i]         <= shadowPhase_q[i];
        end else if (advance) begin
          acc_q[i]   <= sum_d[i][ACC_W-1:0];
          clken_q[i] <= sum_d[i][ACC_W];
        end else begin
          acc_q[i] <= activePhase_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_mf_clken_gen.sv
// Self-checking bench for mf_clken_gen: directed sequence plus random configs,
// compared every cycle against an arithmetic model of lock timing and strobes.
module tb_mf_clken_gen;
  localparam int CHANNELS      = 3;
  localparam int ACC_W         = 32;
  localparam int LOCK_SYNC     = 2;
  localparam int SETTLE_CYCLES = 16;
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                clkSys;
  logic                resetN;
  logic                pllLocked;
  logic                run;
  logic [CHANNELS-1:0] clken;

  mf_clken_gen_if #(.CHANNELS(CHANNELS), .ACC_W(ACC_W)) cfgBus ();

  mf_clken_gen #(
    .CHANNELS(CHANNELS), .ACC_W(ACC_W),
    .LOCK_SYNC(LOCK_SYNC), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk_sys(clkSys), .reset_n(resetN), .pll_locked_i(pllLocked),
    .cfg(cfgBus.slave), .run_o(run), .clken_o(clken)
  );

  initial clkSys = 1'b0;
  always #5 clkSys = ~clkSys;

  int compareCount = 0;
  int failCount    = 0;

  logic [ACC_W-1:0] shInc [CHANNELS];
  logic [ACC_W-1:0] shPhase [CHANNELS];
  logic [ACC_W-1:0] mInc [CHANNELS];
  logic [ACC_W-1:0] mPhase [CHANNELS];
  bit  hist[$];
  bit  mRun;
  bit  mReady;
  int  k;
  int  cycleNo = 0;
  int  strobeCount = 0;
  bit  gapCheck = 0;
  int  lastStrobe = -1;
  int  edges;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < CHANNELS; i++) begin
      shInc[i] = '0; shPhase[i] = '0; mInc[i] = '0; mPhase[i] = '0;
    end
    hist.delete();
    mRun = 0; mReady = 1; k = 0;
  endfunction

  // Running requires SETTLE_CYCLES+1 consecutive high lock samples, seen LOCK_SYNC edges late.
  function automatic bit lockedRun();
    int sz;
    sz = hist.size();
    if (sz < LOCK_SYNC + SETTLE_CYCLES + 1) return 0;
    for (int j = sz - 1 - LOCK_SYNC - SETTLE_CYCLES; j <= sz - 1 - LOCK_SYNC; j++)
      if (!hist[j]) return 0;
    return 1;
  endfunction

  // Strobe in cycle Tk iff phase + k*inc crosses a multiple of 2^ACC_W.
  function automatic logic [CHANNELS-1:0] expClken();
    logic [CHANNELS-1:0] e;
    longint unsigned a, b;
    e = '0;
    if (mRun && k >= 1) begin
      for (int i = 0; i < CHANNELS; i++) begin
        a = 64'(mPhase[i]) + 64'(k) * 64'(mInc[i]);
        b = a - 64'(mInc[i]);
        e[i] = (a >> ACC_W) != (b >> ACC_W);
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input int n);
    bit commitNow;
    bit nowRun;
    for (int c = 0; c < n; c++) begin
      @(posedge clkSys);
      commitNow = cfgBus.cfg_valid && mReady && cfgBus.cfg_commit;
      if (cfgBus.cfg_valid && mReady && !cfgBus.cfg_commit && int'(cfgBus.cfg_ch) < CHANNELS) begin
        shInc[int'(cfgBus.cfg_ch)]   = cfgBus.cfg_inc;
        shPhase[int'(cfgBus.cfg_ch)] = cfgBus.cfg_phase;
      end
      if (commitNow)
        for (int i = 0; i < CHANNELS; i++) begin
          mInc[i] = shInc[i]; mPhase[i] = shPhase[i];
        end
      mReady = !commitNow;
      hist.push_back(pllLocked);
      if (hist.size() > 64) void'(hist.pop_front());
      nowRun = lockedRun();
      if (nowRun) k = (!mRun || commitNow) ? 0 : k + 1;
      mRun = nowRun;
      #1;
      cycleNo++;
      checkOutput("run", 64'(run), 64'(mRun));
      checkOutput("cfgReady", 64'(cfgBus.cfg_ready), 64'(mReady));
      checkOutput("clken", 64'(clken), 64'(expClken()));
      if (clken[0] === 1'b1) begin
        strobeCount++;
        if (gapCheck && lastStrobe >= 0)
          checkOutput("fracGap34", 64'((cycleNo - lastStrobe == 3) || (cycleNo - lastStrobe == 4)), 64'd1);
        lastStrobe = cycleNo;
      end
    end
  endtask

  task automatic cfgShadow(input int ch, input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] phase);
    if (!mReady) applyStimulus(1);
    cfgBus.cfg_valid = 1'b1; cfgBus.cfg_commit = 1'b0;
    cfgBus.cfg_ch = CH_W'(ch); cfgBus.cfg_inc = inc; cfgBus.cfg_phase = phase;
    applyStimulus(1);
    cfgBus.cfg_valid = 1'b0;
  endtask

  task automatic cfgCommit();
    if (!mReady) applyStimulus(1);
    cfgBus.cfg_valid = 1'b1; cfgBus.cfg_commit = 1'b1;
    applyStimulus(1);
    cfgBus.cfg_valid = 1'b0; cfgBus.cfg_commit = 1'b0;
  endtask

  task automatic rateWindow(input string tag, input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] phase,
                            input int window, input int expStrobes);
    cfgShadow(0, inc, phase);
    cfgCommit();
    strobeCount = 0;
    applyStimulus(window);
    checkOutput(tag, 64'(strobeCount), 64'(expStrobes));
  endtask

  task automatic measureRise();
    edges = 0;
    while (run !== 1'b1 && edges < 100) begin
      applyStimulus(1);
      edges++;
    end
    checkOutput("runRiseEdges", 64'(edges), 64'(LOCK_SYNC + 1 + SETTLE_CYCLES));
  endtask

  initial begin
    resetN = 1'b0; pllLocked = 1'b0;
    cfgBus.cfg_valid = 1'b0; cfgBus.cfg_commit = 1'b0;
    cfgBus.cfg_ch = '0; cfgBus.cfg_inc = '0; cfgBus.cfg_phase = '0;
    modelReset();
    repeat (2) @(posedge clkSys);
    #1;
    checkOutput("resetRun", 64'(run), 64'd0);
    checkOutput("resetClken", 64'(clken), 64'd0);
    checkOutput("resetReady", 64'(cfgBus.cfg_ready), 64'd1);
    #1 resetN = 1'b1;

    pllLocked = 1'b1;
    measureRise();
    applyStimulus(20);

    rateWindow("strobes_inc2p31", 32'h8000_0000, 32'h0, 200, 100);
    rateWindow("strobes_inc2p29", 32'h2000_0000, 32'h0, 800, 100);
    rateWindow("strobes_inc2p29_ph2p31", 32'h2000_0000, 32'h8000_0000, 800, 100);

    // Shadow writes without commit, including an out-of-range channel, must not disturb the pattern.
    cfgShadow(1, $urandom, $urandom);
    cfgShadow(0, 32'h4000_0000, 32'h0000_0123);
    cfgShadow(CHANNELS, 32'hFFFF_FFFF, 32'h5);
    applyStimulus(100);
    cfgCommit();
    checkOutput("commitClkenZero", 64'(clken), 64'd0);
    checkOutput("commitReadyLow", 64'(cfgBus.cfg_ready), 64'd0);
    applyStimulus(200);

    cfgShadow(0, 32'h5555_5555, 32'h0);
    cfgCommit();
    applyStimulus(3);
    strobeCount = 0; lastStrobe = -1; gapCheck = 1;
    applyStimulus(3000);
    gapCheck = 0;
    checkOutput("fracStrobes1000", 64'(strobeCount), 64'd1000);

    for (int r = 0; r < 4; r++) begin
      for (int ch = 0; ch < CHANNELS; ch++) cfgShadow(ch, $urandom, $urandom);
      cfgCommit();
      applyStimulus(250);
    end

    pllLocked = 1'b0;
    edges = 0;
    while (run !== 1'b0 && edges < 100) begin
      applyStimulus(1);
      edges++;
    end
    checkOutput("runFallEdges", 64'(edges), 64'(LOCK_SYNC + 1));
    applyStimulus(5);
    pllLocked = 1'b1;
    measureRise();
    applyStimulus(200);

    // Commit lands on the same edge the synchronised lock loss takes effect.
    cfgShadow(0, 32'h8000_0000, 32'h4000_0000);
    cfgShadow(2, 32'h2000_0000, 32'h0);
    pllLocked = 1'b0;
    applyStimulus(LOCK_SYNC);
    cfgCommit();
    checkOutput("commitOnLockLossRun", 64'(run), 64'd0);
    applyStimulus(4);
    pllLocked = 1'b1;
    applyStimulus(LOCK_SYNC + SETTLE_CYCLES + 1 + 200);

    #3 resetN = 1'b0;
    #1;
    checkOutput("asyncResetRun", 64'(run), 64'd0);
    checkOutput("asyncResetClken", 64'(clken), 64'd0);
    checkOutput("asyncResetReady", 64'(cfgBus.cfg_ready), 64'd1);
    modelReset();
    @(posedge clkSys);
    #2 resetN = 1'b1;
    applyStimulus(LOCK_SYNC + SETTLE_CYCLES + 1 + 50);

    cfgShadow(0, 32'h8000_0000, 32'h0);
    cfgCommit();
    applyStimulus(10);
    cfgShadow(1, 32'hC000_0000, 32'h0);
    cfgBus.cfg_valid = 1'b1; cfgBus.cfg_commit = 1'b1;
    #3 resetN = 1'b0;
    #1;
    checkOutput("midCommitResetRun", 64'(run), 64'd0);
    checkOutput("midCommitResetClken", 64'(clken), 64'd0);
    cfgBus.cfg_valid = 1'b0; cfgBus.cfg_commit = 1'b0;
    modelReset();
    @(posedge clkSys);
    #2 resetN = 1'b1;
    strobeCount = 0;
    applyStimulus(LOCK_SYNC + SETTLE_CYCLES + 1 + 100);
    checkOutput("noStrobesAfterReset", 64'(strobeCount), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
